// File: rtl/cw310_reg_master_if.sv
// cw310_reg_master_if: command/response byte streams plus the register-bus signals of cw310_reg_master.
interface cw310_reg_master_if #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7
);
    logic [7:0]                           cmd_data;
    logic                                 cmd_valid;
    logic                                 cmd_ready;
    logic [7:0]                           rsp_data;
    logic                                 rsp_valid;
    logic                                 rsp_ready;
    logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address;
    logic [pBYTECNT_SIZE-1:0]             reg_bytecnt;
    logic [7:0]                           write_data;
    logic [7:0]                           read_data;
    logic                                 reg_read;
    logic                                 reg_write;
    logic                                 reg_addrvalid;
    modport master (
        input  cmd_data, cmd_valid, rsp_ready, read_data,
        output cmd_ready, rsp_data, rsp_valid, reg_address, reg_bytecnt,
               write_data, reg_read, reg_write, reg_addrvalid
    );
    modport slave (
        output cmd_data, cmd_valid, rsp_ready, read_data,
        input  cmd_ready, rsp_data, rsp_valid, reg_address, reg_bytecnt,
               write_data, reg_read, reg_write, reg_addrvalid
    );
endinterface

// File: rtl/cw310_reg_master.sv
// cw310_reg_master: turns a byte-serial command stream into cw310 register-bus read/write cycles.
module cw310_reg_master #(
    parameter int         pADDR_WIDTH   = 21,
    parameter int         pBYTECNT_SIZE = 7,
    parameter int         pTIMEOUT      = 1024,
    parameter logic [7:0] pWR_ACK       = 8'hAC
) (
    input  logic               usb_clk,
    input  logic               reset_i,
    cw310_reg_master_if.master bus,
    output logic               O_busy,
    output logic               O_timeout
);
    localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int TW = $clog2(pTIMEOUT + 2);
    typedef enum logic [3:0] {IDLE, ADDR0, ADDR1, LEN, WR_DATA, WR_ACK, RD_REQ, RD_CAP, RD_SEND} state_t;
    state_t                   r_state, w_next;
    logic                     r_rd, r_wr, r_to;
    logic [7:0]               r_alo, r_len, r_idx, r_wdata, r_rsp;
    logic [AW-1:0]            r_addr;
    logic [pBYTECNT_SIZE-1:0] r_bc;
    logic [TW-1:0]            r_tcnt;
    logic                     w_acc, w_hs, w_cnt, w_to, w_last, w_rd_st;
    assign w_acc   = bus.cmd_valid & bus.cmd_ready;
    assign w_hs    = bus.rsp_valid & bus.rsp_ready;
    assign w_cnt   = r_state inside {ADDR0, ADDR1, LEN, WR_DATA};
    assign w_rd_st = r_state inside {RD_REQ, RD_CAP, RD_SEND};
    assign w_to    = (pTIMEOUT != 0) && w_cnt && !w_acc && (r_tcnt == TW'(pTIMEOUT - 1));
    assign w_last  = (r_idx + 8'd1) == r_len;
    // ready is gated by reset so every output reads 0 while reset is held
    assign bus.cmd_ready     = !reset_i && (w_cnt || r_state == IDLE);
    assign bus.rsp_valid     = r_state inside {WR_ACK, RD_SEND};
    assign bus.rsp_data      = (r_state == WR_ACK) ? pWR_ACK : r_rsp;
    assign bus.reg_read      = r_state inside {RD_REQ, RD_CAP};
    assign bus.reg_write     = r_wr;
    assign bus.write_data    = r_wdata;
    assign bus.reg_address   = r_addr;
    assign bus.reg_bytecnt   = w_rd_st ? r_idx[pBYTECNT_SIZE-1:0] : r_bc;
    assign bus.reg_addrvalid = w_rd_st || r_state == WR_DATA || (r_state == WR_ACK && r_wr);
    assign O_busy            = r_state != IDLE;
    assign O_timeout         = r_to;
    always_ff @(posedge usb_clk or posedge reset_i)
        if (reset_i) r_state <= IDLE;
        else         r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_acc) w_next = ADDR0;
            ADDR0:   if (w_acc) w_next = ADDR1;
            ADDR1:   if (w_acc) w_next = LEN;
            LEN:     if (w_acc) w_next = (bus.cmd_data == 8'd0) ? (r_rd ? IDLE : WR_ACK) : (r_rd ? RD_REQ : WR_DATA);
            WR_DATA: if (w_acc && w_last) w_next = WR_ACK;
            WR_ACK:  if (w_hs) w_next = IDLE;
            RD_REQ:  w_next = RD_CAP;
            RD_CAP:  w_next = RD_SEND;
            RD_SEND: if (w_hs) w_next = w_last ? IDLE : RD_REQ;
            default: w_next = IDLE;
        endcase
        if (w_to) w_next = IDLE;
    end
    always_ff @(posedge usb_clk or posedge reset_i)
        if (reset_i) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_to    <= 1'b0;
            r_alo   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rsp   <= '0;
            r_addr  <= '0;
            r_bc    <= '0;
            r_tcnt  <= '0;
        end else begin
            r_wr   <= (r_state == WR_DATA) && w_acc;
            r_to   <= w_to;
            r_tcnt <= (w_acc || !w_cnt || pTIMEOUT == 0) ? '0 : r_tcnt + TW'(1);
            if (w_acc && r_state == IDLE) r_rd <= bus.cmd_data[7];
            if (w_acc && r_state == ADDR0) r_alo <= bus.cmd_data;
            if (w_acc && r_state == ADDR1) r_addr <= AW'({bus.cmd_data, r_alo});
            if (w_acc && r_state == LEN) begin
                r_len <= bus.cmd_data;
                r_idx <= '0;
            end
            if (w_acc && r_state == WR_DATA) begin
                r_wdata <= bus.cmd_data;
                r_bc    <= r_idx[pBYTECNT_SIZE-1:0];
                r_idx   <= r_idx + 8'd1;
            end
            if (r_state == RD_CAP) r_rsp <= bus.read_data;
            if (r_state == RD_SEND && w_hs) r_idx <= r_idx + 8'd1;
        end
endmodule

// File: tb/tb_cw310_reg_master.sv
// tb_cw310_reg_master: frame table plus scoreboard queues for strobes/responses, and hand-written timeout/reset sequences.
module tb_cw310_reg_master;
    localparam int AW = 14;
    localparam int BW = 7;
    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] addr;
        logic [7:0]  len;
        logic [7:0]  seed;
        int          stall;
        int          exp_nrsp;
    } frame_t;
    logic usb_clk = 1'b0;
    logic reset_i = 1'b1;
    logic busy, tmo;
    int total = 0, passed = 0;
    int stall_left = 0, fr_wr = 0, fr_rd = 0, fr_ovl = 0, fr_rsp = 0;
    logic [28:0] wq[$];
    logic [7:0]  rq[$];
    logic [28:0] e;
    frame_t tbl[6];
    always #5 usb_clk = ~usb_clk;
    cw310_reg_master_if #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(7)) bus();
    cw310_reg_master #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(7), .pTIMEOUT(16), .pWR_ACK(8'hAC)) dut (
        .usb_clk(usb_clk), .reset_i(reset_i), .bus(bus), .O_busy(busy), .O_timeout(tmo)
    );
    // target register model: address 8 holds 2E/04, everything else is a simple address/index hash
    function automatic logic [7:0] tgt(input logic [AW-1:0] a, input logic [BW-1:0] bc);
        if (a == 14'd8) return (bc == 7'd0) ? 8'h2E : ((bc == 7'd1) ? 8'h04 : 8'h00);
        return a[7:0] ^ {bc, 1'b0} ^ 8'h5A;
    endfunction
    assign bus.read_data = tgt(bus.reg_address, bus.reg_bytecnt);
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge usb_clk);
            bus.rsp_ready = !(bus.rsp_valid && stall_left > 0);
            if (bus.rsp_valid && stall_left > 0) stall_left--;
            if (bus.reg_read) fr_rd++;
            if (bus.reg_read && bus.rsp_valid) fr_ovl++;
            if (bus.reg_write) begin
                fr_wr++;
                if (wq.size() == 0) chk("unexpected_write", bus.reg_write, 0);
                else begin
                    e = wq.pop_front();
                    chk("write_addr_bc_data", {bus.reg_address, bus.reg_bytecnt, bus.write_data}, e);
                    chk("write_addrvalid", bus.reg_addrvalid, 1);
                    if (wq.size() == 0) chk("ack_with_last_write", bus.rsp_valid, 1);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                fr_rsp++;
                if (rq.size() == 0) chk("unexpected_rsp", bus.rsp_valid, 0);
                else chk("rsp_data", bus.rsp_data, rq.pop_front());
            end
        end
    end
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.cmd_data  = b;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge usb_clk);
            n++;
        end
        if (n >= 50) chk("cmd_ready_wait", bus.cmd_ready, 1);
        @(negedge usb_clk);
    endtask
    task automatic run_frame(input frame_t f);
        logic [AW-1:0] a = f.addr[AW-1:0];
        logic rd = f.cmd[7];
        int n = 0;
        for (int j = 0; j < int'(f.len); j++)
            if (rd) rq.push_back(tgt(a, j[BW-1:0]));
            else    wq.push_back({a, j[BW-1:0], 8'(int'(f.seed) + j * 17)});
        if (!rd) rq.push_back(8'hAC);
        stall_left = f.stall;
        fr_wr = 0; fr_rd = 0; fr_ovl = 0; fr_rsp = 0;
        send_byte(f.cmd);
        send_byte(f.addr[7:0]);
        send_byte(f.addr[15:8]);
        send_byte(f.len);
        if (!rd) for (int j = 0; j < int'(f.len); j++) send_byte(8'(int'(f.seed) + j * 17));
        bus.cmd_valid = 1'b0;
        while ((busy || rq.size() != 0) && n < 3000) begin
            @(negedge usb_clk);
            n++;
        end
        chk("frame_done_busy", busy, 0);
        chk("frame_nwrites", fr_wr, rd ? 0 : int'(f.len));
        chk("frame_read_cycles", fr_rd, rd ? 2 * int'(f.len) : 0);
        chk("frame_nrsp", fr_rsp, f.exp_nrsp);
        chk("read_during_stall", fr_ovl, 0);
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
    endtask
    initial begin
        int n;
        tbl[0] = '{8'h00, 16'h0005,  8'd3,   8'h11, 0,  1};
        tbl[1] = '{8'h80, 16'h0008,  8'd2,   8'h00, 10, 2};
        tbl[2] = '{8'h80, 16'h0003,  8'd0,   8'h00, 0,  0};
        tbl[3] = '{8'h7F, 16'h1234,  8'd0,   8'h00, 0,  1};
        tbl[4] = '{8'h00, 16'h3FFF,  8'd130, 8'h01, 0,  1};
        tbl[5] = '{8'hC3, 16'hF123,  8'd3,   8'h00, 3,  3};
        bus.cmd_data  = 8'h00;
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge usb_clk);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_reg_write", bus.reg_write, 0);
        chk("rst_reg_read", bus.reg_read, 0);
        chk("rst_addrvalid", bus.reg_addrvalid, 0);
        chk("rst_timeout", tmo, 0);
        chk("rst_address", bus.reg_address, 0);
        reset_i = 1'b0;
        @(negedge usb_clk);
        chk("idle_cmd_ready", bus.cmd_ready, 1);
        // abandoned frame: two bytes then silence
        send_byte(8'h00);
        send_byte(8'h05);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!tmo && n < 40) begin
            @(negedge usb_clk);
            n++;
        end
        chk("timeout_latency", n, 16);
        chk("timeout_busy", busy, 0);
        @(negedge usb_clk);
        chk("timeout_pulse_width", tmo, 0);
        for (int i = 0; i < 6; i++) run_frame(tbl[i]);
        // reset asserted mid-cycle while the read is in its capture cycle
        stall_left = 0;
        send_byte(8'h80);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h04);
        bus.cmd_valid = 1'b0;
        @(posedge usb_clk);
        #2;
        chk("pre_reset_reg_read", bus.reg_read, 1);
        reset_i = 1'b1;
        #1;
        chk("async_rst_reg_read", bus.reg_read, 0);
        chk("async_rst_rsp_valid", bus.rsp_valid, 0);
        chk("async_rst_addrvalid", bus.reg_addrvalid, 0);
        chk("async_rst_busy", busy, 0);
        repeat (2) @(negedge usb_clk);
        reset_i = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge usb_clk);
            if (bus.rsp_valid || bus.reg_read) n++;
        end
        chk("no_stale_activity", n, 0);
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);
        chk("post_rst_busy", busy, 0);
        run_frame(tbl[0]);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
